// File: rtl/brwm_arbiter.sv
// Round-robin arbiter and sequencer sharing one BRWM read/write engine among NREQ requesters.
// Optional WAIT_DONE timeout enabled by defining BRWM_ARB_TIMEOUT_EN.
module brwm_arbiter #(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned DW           = 8,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    req_rw_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  input  logic [NREQ-1:0]    req_last_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [NREQ-1:0]    grant_o,
  output logic               beat_ack_o,
  output logic [DW-1:0]      rd_data_o,
  output logic               rd_valid_o,
  output logic               busy_o,
  output logic               error_o,
  output logic               mem_on_off_o,
  output logic               mem_rw_o,
  output logic               mem_clear_o,
  output logic               mem_pause_o,
  output logic [DW-1:0]      mem_data_in_o,
  input  logic [DW-1:0]      mem_data_out_i,
  input  logic               mem_done_i
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_XFER,
    ST_WAIT,
    ST_REL
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic          rw_q, rw_d;
  logic          flush_pend_q, flush_pend_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic          in_burst;
  logic          beat;

`ifdef BRWM_ARB_TIMEOUT_EN
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic          err_q, err_d;
`endif

  // Rotating priority search starting at the round-robin pointer
  always_comb begin : p_pick
    int unsigned j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_vld && req_i[j]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  assign in_burst = (state_q == ST_XFER) || (state_q == ST_WAIT);
  assign beat     = (state_q == ST_XFER) && !stall_i;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_idx_d    = gnt_idx_q;
    rw_d         = rw_q;
    flush_pend_d = flush_pend_q | flush_i;
    clr_cnt_d    = clr_cnt_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = beat && !rw_q;
`ifdef BRWM_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    err_d        = err_q;
`endif
    if (beat && !rw_q) rd_data_d = mem_data_out_i;

    unique case (state_q)
      ST_IDLE: begin
        if (flush_pend_q) begin
          state_d      = ST_CLEAR;
          flush_pend_d = flush_i;
          clr_cnt_d    = '0;
        end else if (pick_vld) begin
          state_d   = ST_XFER;
          gnt_idx_d = pick_idx;
          rw_d      = req_rw_i[pick_idx];
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) state_d = ST_IDLE;
        else clr_cnt_d = clr_cnt_q + 1'b1;
      end
      ST_XFER: begin
`ifdef BRWM_ARB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        if (beat && req_last_i[gnt_idx_q]) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_done_i) begin
          state_d = ST_REL;
`ifdef BRWM_ARB_TIMEOUT_EN
        end else if (to_cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ST_REL;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
        rr_d    = (gnt_idx_q == IW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      rr_q         <= '0;
      gnt_idx_q    <= '0;
      rw_q         <= 1'b0;
      flush_pend_q <= 1'b0;
      clr_cnt_q    <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_idx_q    <= gnt_idx_d;
      rw_q         <= rw_d;
      flush_pend_q <= flush_pend_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

`ifdef BRWM_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  // Control pins decode from state so reset drops on_off asynchronously
  assign grant_o       = in_burst ? (NREQ'(1) << gnt_idx_q) : '0;
  assign beat_ack_o    = beat;
  assign busy_o        = (state_q != ST_IDLE);
  assign mem_on_off_o  = in_burst || (state_q == ST_CLEAR);
  assign mem_rw_o      = in_burst && rw_q;
  assign mem_clear_o   = (state_q == ST_CLEAR);
  assign mem_pause_o   = in_burst && stall_i;
  assign mem_data_in_o = ((state_q == ST_XFER) && rw_q) ? req_wdata_i[gnt_idx_q*DW +: DW] : '0;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;

endmodule
